spi_slave_fifo: RTL and testbench

SPI_SLAVE_FIFO -- requirements
Module: spi_slave_fifo

---
 rtl/spi_slave_fifo_if.sv | 23 ++
 rtl/spi_slave_fifo.sv | 244 ++++++++++++++++++++++++
 tb/tb_spi_slave_fifo.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_fifo_if.sv
// FIFO-side handshake bundle for spi_slave_fifo.
// slave = block side, master = host logic.
`timescale 1ns/1ps
interface spi_slave_fifo_if #(
  parameter int WORD_W = 8
);
  logic              i_TX_Valid;
  logic              o_TX_Ready;
  logic [WORD_W-1:0] i_TX_Word;
  logic              o_RX_Valid;
  logic              i_RX_Ready;
  logic [WORD_W-1:0] o_RX_Word;

  modport slave (
    input  i_TX_Valid, i_TX_Word, i_RX_Ready,
    output o_TX_Ready, o_RX_Valid, o_RX_Word
  );

  modport master (
    output i_TX_Valid, i_TX_Word, i_RX_Ready,
    input  o_TX_Ready, o_RX_Valid, o_RX_Word
  );
endinterface

// File: rtl/spi_slave_fifo.sv
// SPI slave, oversampled by i_Clk, with TX/RX
// first-word-fall-through FIFOs.
`timescale 1ns/1ps
module spi_slave_fifo #(
  parameter int SPI_MODE   = 0,
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  spi_slave_fifo_if.slave bus,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_TX_Level,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_RX_Level,
  output logic o_TX_Underrun,
  output logic o_RX_Overrun,
  output logic o_Frame_Err,
  output logic o_CS_Active,
  input  logic i_SPI_Clk,
  input  logic i_SPI_MOSI,
  input  logic i_SPI_CS_n,
  output logic o_SPI_MISO,
  output logic o_SPI_OE
);

  localparam bit CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam bit CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int BW = $clog2(WORD_W);

  typedef enum logic [1:0] {IDLE, LOAD, XFER} state_e;

  state_e state_q, state_d;

  logic [1:0] sclk_s_q, mosi_s_q, cs_s_q, vld_q;
  logic       sclk_prev_q, cs_prev_q, armed_q;

  logic [WORD_W-1:0] tx_sr_q, tx_sr_d;
  logic [WORD_W-1:0] rx_sr_q, rx_sr_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic pend_q, pend_d, first_q, first_d;
  logic push_q, push_d;
  logic urun_q, ovr_q, ferr_q, ferr_d;

  logic [WORD_W-1:0] tx_mem_q [FIFO_DEPTH];
  logic [WORD_W-1:0] rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [LW-1:0] tx_cnt_q, rx_cnt_q;

  logic sclk, mosi, cs_n;
  logic rise, fall, lead, trail, cap, lau;
  logic cs_fall, oe, in_load, in_xfer;
  logic exit_f, do_cap, do_lau, tx_load;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic [WORD_W-1:0] tx_head, tx_shift, rx_shift;

  // vld_q marks when the sync chain holds real bus samples,
  // so reset values never count as a CS high.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sclk_s_q    <= {2{CPOL}};
      mosi_s_q    <= '0;
      cs_s_q      <= 2'b11;
      vld_q       <= '0;
      sclk_prev_q <= CPOL;
      cs_prev_q   <= 1'b1;
      armed_q     <= 1'b0;
    end else begin
      sclk_s_q    <= {sclk_s_q[0], i_SPI_Clk};
      mosi_s_q    <= {mosi_s_q[0], i_SPI_MOSI};
      cs_s_q      <= {cs_s_q[0], i_SPI_CS_n};
      vld_q       <= {vld_q[0], 1'b1};
      sclk_prev_q <= sclk_s_q[1];
      cs_prev_q   <= cs_s_q[1];
      armed_q     <= armed_q | (vld_q[1] & cs_s_q[1]);
    end
  end

  assign sclk  = sclk_s_q[1];
  assign mosi  = mosi_s_q[1];
  assign cs_n  = cs_s_q[1];
  assign rise  = sclk & ~sclk_prev_q;
  assign fall  = ~sclk & sclk_prev_q;
  assign lead  = CPOL ? fall : rise;
  assign trail = CPOL ? rise : fall;
  assign cap   = CPHA ? trail : lead;
  assign lau   = CPHA ? lead : trail;

  assign cs_fall = armed_q & cs_prev_q & ~cs_n;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cs_fall) state_d = LOAD;
      LOAD:    state_d = XFER;
      XFER:    if (cs_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    oe      = 1'b0;
    in_load = 1'b0;
    in_xfer = 1'b0;
    unique case (state_q)
      IDLE: ;
      LOAD: begin
        oe      = 1'b1;
        in_load = 1'b1;
      end
      XFER: begin
        oe      = 1'b1;
        in_xfer = 1'b1;
      end
      default: ;
    endcase
  end

  assign exit_f  = in_xfer & cs_n;
  assign do_cap  = in_xfer & ~cs_n & cap;
  assign do_lau  = in_xfer & ~cs_n & lau;
  assign tx_load = in_load | (do_lau & pend_q);

  assign tx_head  = tx_empty ? '0 : tx_mem_q[tx_rp_q];
  assign tx_shift = MSB_FIRST ? {tx_sr_q[WORD_W-2:0], 1'b0}
                              : {1'b0, tx_sr_q[WORD_W-1:1]};
  assign rx_shift = MSB_FIRST ? {rx_sr_q[WORD_W-2:0], mosi}
                              : {mosi, rx_sr_q[WORD_W-1:1]};

  always_comb begin
    tx_sr_d = tx_sr_q;
    rx_sr_d = rx_sr_q;
    bcnt_d  = bcnt_q;
    pend_d  = pend_q;
    first_d = first_q;
    push_d  = 1'b0;
    ferr_d  = 1'b0;
    if (exit_f) begin
      tx_sr_d = '0;
      bcnt_d  = '0;
      pend_d  = 1'b0;
      first_d = 1'b0;
      ferr_d  = (bcnt_q != '0);
    end else begin
      if (tx_load) begin
        tx_sr_d = tx_head;
        pend_d  = 1'b0;
        first_d = in_load & CPHA;
      end else if (do_lau) begin
        if (first_q) first_d = 1'b0;
        else         tx_sr_d = tx_shift;
      end
      if (do_cap) begin
        rx_sr_d = rx_shift;
        if (bcnt_q == BW'(WORD_W-1)) begin
          bcnt_d = '0;
          push_d = 1'b1;
          pend_d = 1'b1;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      tx_sr_q <= '0;
      rx_sr_q <= '0;
      bcnt_q  <= '0;
      pend_q  <= 1'b0;
      first_q <= 1'b0;
      push_q  <= 1'b0;
      urun_q  <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      tx_sr_q <= tx_sr_d;
      rx_sr_q <= rx_sr_d;
      bcnt_q  <= bcnt_d;
      pend_q  <= pend_d;
      first_q <= first_d;
      push_q  <= push_d;
      urun_q  <= tx_load & tx_empty;
      ovr_q   <= push_q & rx_full & ~rx_pop;
      ferr_q  <= ferr_d;
    end
  end

  assign tx_full  = (tx_cnt_q == LW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == LW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  assign tx_push = bus.i_TX_Valid & ~tx_full;
  assign tx_pop  = tx_load & ~tx_empty;
  assign rx_pop  = bus.i_RX_Ready & ~rx_empty;
  assign rx_push = push_q & (~rx_full | rx_pop);

  always_ff @(posedge i_Clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= bus.i_TX_Word;
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_sr_q;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      tx_wp_q  <= tx_wp_q + AW'(tx_push);
      tx_rp_q  <= tx_rp_q + AW'(tx_pop);
      tx_cnt_q <= tx_cnt_q + LW'(tx_push) - LW'(tx_pop);
      rx_wp_q  <= rx_wp_q + AW'(rx_push);
      rx_rp_q  <= rx_rp_q + AW'(rx_pop);
      rx_cnt_q <= rx_cnt_q + LW'(rx_push) - LW'(rx_pop);
    end
  end

  assign bus.o_TX_Ready = ~tx_full;
  assign bus.o_RX_Valid = ~rx_empty;
  assign bus.o_RX_Word  = rx_empty ? '0 : rx_mem_q[rx_rp_q];

  assign o_TX_Level    = tx_cnt_q;
  assign o_RX_Level    = rx_cnt_q;
  assign o_TX_Underrun = urun_q;
  assign o_RX_Overrun  = ovr_q;
  assign o_Frame_Err   = ferr_q;
  assign o_CS_Active   = armed_q & ~cs_n;
  assign o_SPI_OE      = oe;
  assign o_SPI_MISO    = oe & (MSB_FIRST ? tx_sr_q[WORD_W-1]
                                         : tx_sr_q[0]);

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Scoreboard bench for spi_slave_fifo: one instance per
// SPI mode sharing SCLK/MOSI, separate chip selects.
`timescale 1ns/1ps
module tb_spi_slave_fifo;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic sclk, mosi;
  logic [3:0] cs_n;
  logic [3:0] tx_valid, tx_ready, rx_valid, rx_ready;
  logic [3:0] miso, oe, urun, ovr, ferr, csa;
  logic [W-1:0] tx_word;
  logic [W-1:0] rx_word [4];
  logic [2:0] tx_lvl [4];
  logic [2:0] rx_lvl [4];

  int errs = 0;
  int checks = 0;
  int urun_n [4] = '{0, 0, 0, 0};
  int ovr_n  [4] = '{0, 0, 0, 0};
  int ferr_n [4] = '{0, 0, 0, 0};

  logic [W-1:0] rx_exp_q [$];
  logic [W-1:0] miso_exp_q [$];
  logic [W-1:0] mo_buf [8];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_fifo_if #(.WORD_W(W)) bus ();
    assign bus.i_TX_Valid = tx_valid[g];
    assign bus.i_TX_Word  = tx_word;
    assign bus.i_RX_Ready = rx_ready[g];
    assign tx_ready[g]    = bus.o_TX_Ready;
    assign rx_valid[g]    = bus.o_RX_Valid;
    assign rx_word[g]     = bus.o_RX_Word;

    spi_slave_fifo #(
      .SPI_MODE(g), .WORD_W(W),
      .FIFO_DEPTH(4), .MSB_FIRST(1'b1)
    ) dut (
      .i_Clk(clk),
      .i_Rst_L(rst_n),
      .bus(bus),
      .o_TX_Level(tx_lvl[g]),
      .o_RX_Level(rx_lvl[g]),
      .o_TX_Underrun(urun[g]),
      .o_RX_Overrun(ovr[g]),
      .o_Frame_Err(ferr[g]),
      .o_CS_Active(csa[g]),
      .i_SPI_Clk(sclk),
      .i_SPI_MOSI(mosi),
      .i_SPI_CS_n(cs_n[g]),
      .o_SPI_MISO(miso[g]),
      .o_SPI_OE(oe[g])
    );
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (urun[i]) urun_n[i]++;
      if (ovr[i])  ovr_n[i]++;
      if (ferr[i]) ferr_n[i]++;
    end
  end

  // RX monitor: every accepted pop is checked against the queue
  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (rx_valid[i] && rx_ready[i]) begin
          if (rx_exp_q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL rx_unexpected: got %0h expected none",
                     rx_word[i]);
          end else begin
            chk("rx_word", 32'(rx_word[i]), 32'(rx_exp_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input int m, input logic [W-1:0] w);
    chk("tx_ready", 32'(tx_ready[m]), 32'd1);
    tx_word = w;
    tx_valid[m] = 1'b1;
    @(negedge clk);
    tx_valid[m] = 1'b0;
  endtask

  task automatic spi_word(input int m, input logic [W-1:0] tx,
                          input int nbits, input bit chk_miso,
                          input bit pop_end);
    logic [W-1:0] got;
    logic a, b;
    bit stable;
    bit cpha;
    int idx;
    got = '0;
    stable = 1'b1;
    cpha = (m % 2) == 1;
    b = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      idx = W - 1 - i;
      if (cpha) sclk = ~sclk;
      mosi = tx[idx];
      idle(8);
      a = miso[m];
      sclk = ~sclk;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (k == 2) b = miso[m];
        if (pop_end && i == nbits - 1) begin
          if (k == 3) rx_ready[m] = 1'b1;
          if (k == 4) rx_ready[m] = 1'b0;
        end
      end
      if (!cpha) sclk = ~sclk;
      got[idx] = a;
      if (a !== b) stable = 1'b0;
    end
    if (chk_miso) begin
      chk("miso_word", 32'(got), 32'(miso_exp_q.pop_front()));
      chk("miso_stable", 32'(stable), 32'd1);
    end
  endtask

  task automatic spi_frame(input int m, input int nw,
                           input int nb_last, input bit pop_end);
    sclk = (m >= 2);
    idle(8);
    cs_n[m] = 1'b0;
    idle(8);
    chk("oe_active", 32'({oe[m], csa[m]}), 32'b11);
    for (int w = 0; w < nw; w++) begin
      spi_word(m, mo_buf[w], (w == nw - 1) ? nb_last : W,
               (w < nw - 1) || (nb_last == W),
               pop_end && (w == nw - 1));
    end
    idle(8);
    cs_n[m] = 1'b1;
    idle(16);
    chk("oe_idle", 32'({oe[m], miso[m], csa[m]}), 32'd0);
  endtask

  int base_u, base_o, base_f;
  logic [W-1:0] mtx [4];
  logic [W-1:0] mrx [4];

  initial begin
    rst_n = 1'b0;
    sclk = 1'b0;
    mosi = 1'b0;
    cs_n = 4'hF;
    tx_valid = '0;
    tx_word = '0;
    rx_ready = '0;
    idle(5);

    chk("rst_tx_ready", 32'(tx_ready), 32'hF);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_oe_miso", 32'({oe, miso}), 32'h0);
    chk("rst_cs_active", 32'(csa), 32'h0);
    chk("rst_pulses", 32'({urun, ovr, ferr}), 32'h0);
    chk("rst_rx_word", 32'(rx_word[0]), 32'h0);
    chk("rst_levels", 32'({tx_lvl[0], rx_lvl[0]}), 32'h0);
    rst_n = 1'b1;
    idle(6);

    // mode 0 single word, level 0 -> 1
    push_tx(0, 8'hA5);
    chk("m0_tx_level", 32'(tx_lvl[0]), 32'd1);
    chk("m0_rx_level0", 32'(rx_lvl[0]), 32'd0);
    miso_exp_q.push_back(8'hA5);
    rx_exp_q.push_back(8'h3C);
    mo_buf[0] = 8'h3C;
    spi_frame(0, 1, W, 1'b0);
    chk("m0_rx_level1", 32'(rx_lvl[0]), 32'd1);
    chk("m0_rx_valid", 32'(rx_valid[0]), 32'd1);
    rx_ready[0] = 1'b1;
    idle(3);
    rx_ready[0] = 1'b0;
    chk("m0_drained", 32'(rx_lvl[0]), 32'd0);

    // modes 1..3, one word each
    mtx = '{8'h00, 8'h96, 8'hC3, 8'h0F};
    mrx = '{8'h00, 8'h69, 8'hE1, 8'hF0};
    for (int m = 1; m < 4; m++) begin
      rx_ready[m] = 1'b1;
      push_tx(m, mtx[m]);
      miso_exp_q.push_back(mtx[m]);
      rx_exp_q.push_back(mrx[m]);
      mo_buf[0] = mrx[m];
      spi_frame(m, 1, W, 1'b0);
      chk("mode_rx_done", 32'(rx_exp_q.size()), 32'd0);
    end

    // TX underrun on word 4 of a 4-word frame
    base_u = urun_n[1];
    push_tx(1, 8'h11);
    push_tx(1, 8'h22);
    push_tx(1, 8'h33);
    chk("ur_tx_level", 32'(tx_lvl[1]), 32'd3);
    miso_exp_q.push_back(8'h11);
    miso_exp_q.push_back(8'h22);
    miso_exp_q.push_back(8'h33);
    miso_exp_q.push_back(8'h00);
    mo_buf[0] = 8'h01; mo_buf[1] = 8'h02;
    mo_buf[2] = 8'h03; mo_buf[3] = 8'h04;
    for (int i = 1; i <= 4; i++) rx_exp_q.push_back(8'(i));
    spi_frame(1, 4, W, 1'b0);
    chk("ur_count", 32'(urun_n[1] - base_u), 32'd1);
    chk("ur_tx_empty", 32'(tx_lvl[1]), 32'd0);
    rx_ready[1] = 1'b0;

    // RX overrun: 5 words, no consumer
    base_o = ovr_n[0];
    for (int i = 0; i < 5; i++) begin
      mo_buf[i] = 8'hC1 + 8'(i);
      miso_exp_q.push_back(8'h00);
      if (i < 4) rx_exp_q.push_back(8'hC1 + 8'(i));
    end
    spi_frame(0, 5, W, 1'b0);
    chk("ov_rx_level", 32'(rx_lvl[0]), 32'd4);
    chk("ov_count", 32'(ovr_n[0] - base_o), 32'd1);

    // full FIFO, pop coincident with push: no overrun
    mo_buf[0] = 8'hD7;
    miso_exp_q.push_back(8'h00);
    rx_exp_q.push_back(8'hD7);
    spi_frame(0, 1, W, 1'b1);
    chk("ov_popush_count", 32'(ovr_n[0] - base_o), 32'd1);
    chk("ov_popush_level", 32'(rx_lvl[0]), 32'd4);
    rx_ready[0] = 1'b1;
    idle(8);
    rx_ready[0] = 1'b0;
    chk("ov_drained", 32'(rx_exp_q.size()), 32'd0);

    // frame error after 5 bits
    base_f = ferr_n[0];
    mo_buf[0] = 8'hFF;
    spi_frame(0, 1, 5, 1'b0);
    chk("fe_count", 32'(ferr_n[0] - base_f), 32'd1);
    chk("fe_rx_level", 32'(rx_lvl[0]), 32'd0);
    push_tx(0, 8'h3E);
    miso_exp_q.push_back(8'h3E);
    rx_exp_q.push_back(8'h81);
    mo_buf[0] = 8'h81;
    spi_frame(0, 1, W, 1'b0);
    chk("fe_next_level", 32'(rx_lvl[0]), 32'd1);
    chk("fe_count_after", 32'(ferr_n[0] - base_f), 32'd1);
    rx_ready[0] = 1'b1;
    idle(4);
    rx_ready[0] = 1'b0;

    // reset mid-word with CS held low
    push_tx(0, 8'h77);
    sclk = 1'b0;
    idle(8);
    cs_n[0] = 1'b0;
    idle(8);
    spi_word(0, 8'hAB, 4, 1'b0, 1'b0);
    base_u = urun_n[0];
    base_f = ferr_n[0];
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    spi_word(0, 8'hAB, W, 1'b0, 1'b0);
    idle(8);
    chk("rs_rx_level", 32'(rx_lvl[0]), 32'd0);
    chk("rs_ignored", 32'({oe[0], csa[0]}), 32'd0);
    chk("rs_pulses", 32'((urun_n[0] - base_u) + (ferr_n[0] - base_f)),
        32'd0);
    cs_n[0] = 1'b1;
    idle(16);
    push_tx(0, 8'h4D);
    miso_exp_q.push_back(8'h4D);
    rx_exp_q.push_back(8'hB2);
    mo_buf[0] = 8'hB2;
    spi_frame(0, 1, W, 1'b0);
    chk("rs_resume_level", 32'(rx_lvl[0]), 32'd1);
    rx_ready[0] = 1'b1;
    idle(6);
    rx_ready[0] = 1'b0;

    idle(10);
    chk("rx_queue_empty", 32'(rx_exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
